thor2023_thread_sched: RTL and testbench
========================================

THOR2023_THREAD_SCHED -- requirements
Module: thor2023_thread_sched

Interface
REQ-001 SHALL have parameter NTHREADS, default 4, number of hardware threads scheduled.
REQ-002 SHALL have parameter IMISS_MAX, default 31, I$-miss timeout in cycles; range 1..31.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sleep_i  input  NTHREADS  per-thread sleep request, one-cycle pulse.
REQ-006 SHALL have port wake_i  input  NTHREADS  per-thread wake request, one-cycle pulse.
REQ-007 SHALL have port imiss_i  input  1  I$ miss reported for thread imiss_tid_i.
REQ-008 SHALL have port imiss_tid_i  input  $clog2(NTHREADS)  thread id of the miss.
REQ-009 SHALL have port imiss_done_i  input  1  miss refill complete for thread imiss_done_tid_i.
REQ-010 SHALL have port imiss_done_tid_i  input  $clog2(NTHREADS)  thread id of the completed refill.
REQ-011 SHALL have port fetch_rdy_i  input  1  fetch stage accepts the granted thread this cycle.
REQ-012 SHALL have port tid_o  output  $clog2(NTHREADS)  granted thread id.
REQ-013 SHALL have port tid_v_o  output  1  tid_o is valid (at least one thread eligible).
REQ-014 SHALL have port eligible_o  output  NTHREADS  per-thread eligibility vector.
REQ-015 SHALL have port idle_o  output  1  all threads sleeping.

Function
REQ-016 SHALL hold per-thread state: sleep_r, miss_r, and a round-robin pointer ptr.
REQ-017 SHALL compute eligible_o[t] = ~sleep_r[t] & ~miss_r[t], from registered state only.
REQ-018 SHALL drive tid_o as the first eligible thread found searching upward from ptr, wrapping at NTHREADS-1 to 0; tid_v_o = |eligible_o.
REQ-019 SHALL hold tid_o = ptr when tid_v_o = 0.
REQ-020 SHALL apply input events to state at the clock edge, so they affect tid_o/eligible_o in the next cycle (latency 1).
REQ-021 SHALL advance ptr to (tid_o+1) mod NTHREADS only when fetch_rdy_i & tid_v_o; otherwise ptr holds and the grant is stable.
REQ-022 SHALL set sleep_r[t] on sleep_i[t] and clear it on wake_i[t]; both set in one cycle: wake wins.
REQ-023 SHALL set miss_r[imiss_tid_i] on imiss_i and clear miss_r[imiss_done_tid_i] on imiss_done_i; same thread same cycle: set wins (new miss).
REQ-024 SHALL allow miss and sleep state to coexist independently; a thread is eligible only when both are clear.
REQ-025 SHALL assert idle_o when &sleep_r.
REQ-026 SHALL ignore out-of-range thread ids (>= NTHREADS) on imiss_tid_i / imiss_done_tid_i.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, set ptr=0, miss_r=0, all timeout counters=0, sleep_r=all ones except thread 0 cleared.
REQ-028 SHALL present after reset: tid_o=0, tid_v_o=1, eligible_o=0001 (NTHREADS=4), idle_o=0.
REQ-029 SHALL let reset override every concurrent input event, including mid-miss and mid-grant.

Configuration
REQ-030 SHALL, when THOR2023_TSCHED_IMISS_TIMEOUT_EN is defined, include a 5-bit per-thread counter loaded with IMISS_MAX on imiss_i, decremented each cycle while miss_r set, clearing miss_r on the cycle it reaches 0; imiss_done_i also clears miss_r and the counter.
REQ-031 SHALL, when THOR2023_TSCHED_IMISS_TIMEOUT_EN is undefined, omit the counters; miss_r clears only on imiss_done_i.

Verification
REQ-032 SHALL cover: reset, then wake_i=1110 one cycle, fetch_rdy_i=1 held -> tid_o sequence 0,0,1,2,3,0 with tid_v_o=1.
REQ-033 SHALL cover: all awake, imiss_i tid 2 -> next cycles tid_o skips 2 (0,1,3,0); imiss_done_i tid 2 -> thread 2 granted again within one rotation.
REQ-034 SHALL cover: fetch_rdy_i=0 for 5 cycles with all threads eligible -> tid_o constant, ptr unchanged.
REQ-035 SHALL cover: sleep_i=1111 -> next cycle idle_o=1, tid_v_o=0, tid_o=ptr; sleep_i[1] and wake_i[1] same cycle -> thread 1 awake.
REQ-036 SHALL cover: imiss_i and imiss_done_i both tid 3 same cycle -> miss_r[3]=1; rst_n low during miss -> miss_r=0, tid_o=0.
REQ-037 SHALL cover, with THOR2023_TSCHED_IMISS_TIMEOUT_EN and IMISS_MAX=4: imiss_i tid 1, no done -> eligible_o[1] returns to 1 exactly 5 cycles after the miss edge; without the macro it stays 0.

Source files
------------

// File: rtl/thor2023_thread_sched.sv
// thor2023_thread_sched: round-robin scheduler for NTHREADS hardware threads.
// A thread is eligible when it is neither sleeping nor waiting on an I$ miss;
// the grant is the first eligible thread at or above the rotating pointer.
// Optional feature: define THOR2023_TSCHED_IMISS_TIMEOUT_EN to add per-thread
// I$-miss timeout counters that release a stuck miss after IMISS_MAX cycles.
module thor2023_thread_sched #(
    parameter int NTHREADS  = 4,
    parameter int IMISS_MAX = 31
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NTHREADS-1:0]         sleep_i,
    input  logic [NTHREADS-1:0]         wake_i,
    input  logic                        imiss_i,
    input  logic [$clog2(NTHREADS)-1:0] imiss_tid_i,
    input  logic                        imiss_done_i,
    input  logic [$clog2(NTHREADS)-1:0] imiss_done_tid_i,
    input  logic                        fetch_rdy_i,
    output logic [$clog2(NTHREADS)-1:0] tid_o,
    output logic                        tid_v_o,
    output logic [NTHREADS-1:0]         eligible_o,
    output logic                        idle_o
);
    localparam int TW = $clog2(NTHREADS);
    // Only thread 0 comes out of reset awake.
    localparam logic [NTHREADS-1:0] SLEEP_RST = ~NTHREADS'(1);

    logic [NTHREADS-1:0] sleep_q, sleep_d;
    logic [NTHREADS-1:0] miss_q, miss_d;
    logic [TW-1:0]       ptr_q, ptr_d;
    logic [NTHREADS-1:0] elig;
    logic [TW-1:0]       grant;
    logic                grant_v;
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
    logic [4:0]          cnt_q [NTHREADS];
    logic [4:0]          cnt_d [NTHREADS];
`endif

    assign elig       = ~sleep_q & ~miss_q;
    assign tid_o      = grant;
    assign tid_v_o    = grant_v;
    assign eligible_o = elig;
    assign idle_o     = &sleep_q;

    // Rotating-priority search: first eligible thread from ptr upward, wrapping; ptr when none.
    always_comb begin
        int unsigned   idx;
        logic [TW-1:0] idx_tw;
        idx     = 0;
        idx_tw  = '0;
        grant   = ptr_q;
        grant_v = 1'b0;
        for (int unsigned off = 0; off < NTHREADS; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NTHREADS) begin
                idx = idx - NTHREADS;
            end
            idx_tw = TW'(idx);
            if (!grant_v && elig[idx_tw]) begin
                grant_v = 1'b1;
                grant   = idx_tw;
            end
        end
    end

    // Pointer moves past the granted thread only when fetch accepts it.
    always_comb begin
        ptr_d = ptr_q;
        if (fetch_rdy_i && grant_v) begin
            ptr_d = (grant == TW'(NTHREADS - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Sleep/wake: wake has priority over a simultaneous sleep.
    always_comb begin
        sleep_d = (sleep_q | sleep_i) & ~wake_i;
    end

    // Miss tracking; priority is new miss, then refill done, then timeout expiry.
    // Matching ids against each loop index makes out-of-range ids fall through.
    always_comb begin
        miss_d = miss_q;
        for (int unsigned t = 0; t < NTHREADS; t++) begin
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
            cnt_d[t] = cnt_q[t];
            if (miss_q[t]) begin
                if (cnt_q[t] == '0) begin
                    miss_d[t] = 1'b0;
                end else begin
                    cnt_d[t] = cnt_q[t] - 5'd1;
                end
            end
`endif
            if (imiss_done_i && (imiss_done_tid_i == TW'(t))) begin
                miss_d[t] = 1'b0;
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
                cnt_d[t]  = '0;
`endif
            end
            if (imiss_i && (imiss_tid_i == TW'(t))) begin
                miss_d[t] = 1'b1;
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
                cnt_d[t]  = 5'(IMISS_MAX);
`endif
            end
        end
    end

    // State registers; synchronous reset overrides every concurrent event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sleep_q <= SLEEP_RST;
            miss_q  <= '0;
            ptr_q   <= '0;
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
            for (int unsigned t = 0; t < NTHREADS; t++) begin
                cnt_q[t] <= '0;
            end
`endif
        end else begin
            sleep_q <= sleep_d;
            miss_q  <= miss_d;
            ptr_q   <= ptr_d;
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
            for (int unsigned t = 0; t < NTHREADS; t++) begin
                cnt_q[t] <= cnt_d[t];
            end
`endif
        end
    end
endmodule

// File: tb/tb_thor2023_thread_sched.sv
// Bench for thor2023_thread_sched (NTHREADS=4, IMISS_MAX=4): directed vector
// table, hand-written corner sequences and a randomized run against a model.
module tb_thor2023_thread_sched;
    localparam int N    = 4;
    localparam int IMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sleep_i, wake_i;
    logic       imiss_i, imiss_done_i, fetch_rdy_i;
    logic [1:0] imiss_tid_i, imiss_done_tid_i;
    logic [1:0] tid_o;
    logic       tid_v_o;
    logic [3:0] eligible_o;
    logic       idle_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_sleep [N];
    int m_miss  [N];
    int m_cnt   [N];
    int m_ptr;

    typedef struct {
        logic       rst_n;
        logic [3:0] sleep;
        logic [3:0] wake;
        logic       imiss;
        logic [1:0] itid;
        logic       done;
        logic [1:0] dtid;
        logic       frdy;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [1:0] etid;
        logic       ev;
        logic [3:0] eelig;
        logic       eidle;
    } vec_t;

    thor2023_thread_sched #(.NTHREADS(N), .IMISS_MAX(IMAX)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sleep_i          (sleep_i),
        .wake_i           (wake_i),
        .imiss_i          (imiss_i),
        .imiss_tid_i      (imiss_tid_i),
        .imiss_done_i     (imiss_done_i),
        .imiss_done_tid_i (imiss_done_tid_i),
        .fetch_rdy_i      (fetch_rdy_i),
        .tid_o            (tid_o),
        .tid_v_o          (tid_v_o),
        .eligible_o       (eligible_o),
        .idle_o           (idle_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic stim_t mk(input logic r, input logic [3:0] sl, input logic [3:0] wk,
                                 input logic im, input logic [1:0] it, input logic dn,
                                 input logic [1:0] dt, input logic fr);
        stim_t s;
        s.rst_n = r; s.sleep = sl; s.wake = wk; s.imiss = im; s.itid = it;
        s.done = dn; s.dtid = dt; s.frdy = fr;
        return s;
    endfunction

    function automatic vec_t v(input logic [3:0] sl, input logic [3:0] wk, input logic im,
                               input logic [1:0] it, input logic dn, input logic [1:0] dt,
                               input logic fr, input logic [1:0] etid, input logic ev,
                               input logic [3:0] eel, input logic eidle);
        vec_t r;
        r.s = mk(1'b1, sl, wk, im, it, dn, dt, fr);
        r.etid = etid; r.ev = ev; r.eelig = eel; r.eidle = eidle;
        return r;
    endfunction

    // Model: thread eligible when awake and not missing
    function automatic int m_elig(input int t);
        return (m_sleep[t] == 0 && m_miss[t] == 0) ? 1 : 0;
    endfunction

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            if (m_elig((m_ptr + k) % N) != 0) return (m_ptr + k) % N;
        end
        return m_ptr;
    endfunction

    function automatic int m_valid();
        for (int t = 0; t < N; t++) if (m_elig(t) != 0) return 1;
        return 0;
    endfunction

    task automatic model_update(input stim_t s);
        int g, vld;
        if (!s.rst_n) begin
            m_ptr = 0;
            for (int t = 0; t < N; t++) begin
                m_sleep[t] = (t == 0) ? 0 : 1;
                m_miss[t]  = 0;
                m_cnt[t]   = 0;
            end
        end else begin
            g   = m_grant();
            vld = m_valid();
            if (s.frdy && vld != 0) m_ptr = (g + 1) % N;
            for (int t = 0; t < N; t++) begin
                if (s.wake[t])       m_sleep[t] = 0;
                else if (s.sleep[t]) m_sleep[t] = 1;
                if (s.imiss && int'(s.itid) == t) begin
                    m_miss[t] = 1;
                    m_cnt[t]  = IMAX;
                end else if (s.done && int'(s.dtid) == t) begin
                    m_miss[t] = 0;
                    m_cnt[t]  = 0;
                end
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
                else if (m_miss[t] != 0) begin
                    if (m_cnt[t] == 0) m_miss[t] = 0;
                    else               m_cnt[t]  = m_cnt[t] - 1;
                end
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, keep the model in step
    task automatic step(input stim_t s);
        rst_n            = s.rst_n;
        sleep_i          = s.sleep;
        wake_i           = s.wake;
        imiss_i          = s.imiss;
        imiss_tid_i      = s.itid;
        imiss_done_i     = s.done;
        imiss_done_tid_i = s.dtid;
        fetch_rdy_i      = s.frdy;
        @(posedge clk);
        model_update(s);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [1:0] etid, input logic ev,
                         input logic [3:0] eel, input logic eidle);
        n_checks++;
        if ({tid_o, tid_v_o, eligible_o, idle_o} === {etid, ev, eel, eidle}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got tid=%0d v=%b elig=%b idle=%b, expected tid=%0d v=%b elig=%b idle=%b",
                     name, tid_o, tid_v_o, eligible_o, idle_o, etid, ev, eel, eidle);
        end
    endtask

    task automatic check_model(input string name);
        logic [3:0] e;
        logic       idl;
        idl = 1'b1;
        for (int t = 0; t < N; t++) begin
            e[t] = (m_elig(t) != 0);
            if (m_sleep[t] == 0) idl = 1'b0;
        end
        check(name, 2'(m_grant()), (m_valid() != 0), e, idl);
    endtask

    stim_t idle_s;
    vec_t  tbl [27];

    initial begin
        idle_s = mk(1'b1, 4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        // Rows: inputs for the cycle, outputs expected during that cycle
        tbl[0]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 4'b0001, 0);
        tbl[1]  = v(4'b0000, 4'b1110, 0, 0, 0, 0, 1, 0, 1, 4'b0001, 0);
        tbl[2]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 1, 4'b1111, 0);
        tbl[3]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 2, 1, 4'b1111, 0);
        tbl[4]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 3, 1, 4'b1111, 0);
        tbl[5]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 4'b1111, 0);
        tbl[6]  = v(4'b0000, 4'b0000, 1, 2, 0, 0, 1, 1, 1, 4'b1111, 0);
        tbl[7]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 3, 1, 4'b1011, 0);
        tbl[8]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 4'b1011, 0);
        tbl[9]  = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 1, 4'b1011, 0);
        tbl[10] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 3, 1, 4'b1011, 0);
        tbl[11] = v(4'b0000, 4'b0000, 0, 0, 1, 2, 1, 0, 1, 4'b1011, 0);
        tbl[12] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 1, 4'b1111, 0);
        tbl[13] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 2, 1, 4'b1111, 0);
        for (int i = 14; i < 19; i++)
            tbl[i] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3, 1, 4'b1111, 0);
        tbl[19] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 3, 1, 4'b1111, 0);
        tbl[20] = v(4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0, 1, 4'b1111, 0);
        tbl[21] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 1);
        tbl[22] = v(4'b0010, 4'b0010, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 1);
        tbl[23] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 0);
        tbl[24] = v(4'b0000, 4'b1111, 0, 0, 0, 0, 0, 1, 1, 4'b0010, 0);
        tbl[25] = v(4'b0000, 4'b0000, 1, 3, 1, 3, 0, 1, 1, 4'b1111, 0);
        tbl[26] = v(4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 4'b0111, 0);

        @(negedge clk);
        step(mk(1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        step(mk(1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        check("reset_state", 2'd0, 1'b1, 4'b0001, 1'b0);

        // Directed vector table
        for (int i = 0; i < 27; i++) begin
            check($sformatf("vec%0d", i), tbl[i].etid, tbl[i].ev, tbl[i].eelig, tbl[i].eidle);
            step(tbl[i].s);
        end

        // Reset while thread 3 is missing and a new miss/grant is in flight
        step(mk(1'b0, 4'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1));
        check("reset_mid_miss", 2'd0, 1'b1, 4'b0001, 1'b0);
        step(mk(1'b1, 4'b0, 4'b1110, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        check("miss_cleared_by_reset", 2'd0, 1'b1, 4'b1111, 1'b0);

        // Miss on thread 1 with no refill: timeout release (or not) after the miss edge
        step(mk(1'b1, 4'b0, 4'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0));
        for (int k = 0; k < 8; k++) begin
            n_checks++;
`ifdef THOR2023_TSCHED_IMISS_TIMEOUT_EN
            if (eligible_o[1] === ((k >= 5) ? 1'b1 : 1'b0)) n_pass++;
            else $display("FAIL timeout_k%0d: got elig1=%b expected %b", k, eligible_o[1], (k >= 5));
`else
            if (eligible_o[1] === 1'b0) n_pass++;
            else $display("FAIL no_timeout_k%0d: got elig1=%b expected 0", k, eligible_o[1]);
`endif
            step(idle_s);
        end

        // Randomized run against the model, with occasional resets
        step(mk(1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            check_model($sformatf("rand%0d", i));
            s.rst_n = ($urandom_range(0, 49) != 0);
            s.sleep = 4'($urandom) & 4'($urandom) & 4'($urandom);
            s.wake  = 4'($urandom) & 4'($urandom);
            s.imiss = ($urandom_range(0, 3) == 0);
            s.itid  = 2'($urandom);
            s.done  = ($urandom_range(0, 2) == 0);
            s.dtid  = 2'($urandom);
            s.frdy  = ($urandom_range(0, 3) != 0);
            step(s);
        end
        check_model("rand_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
